// File: rtl/key_debouncer.sv
// Push-button conditioner: two-flop synchroniser, per-key stability-counter debounce,
// registered active-high level plus one-cycle press/release pulses.
// Optional auto-repeat press pulses while held: define KEY_AUTOREPEAT_EN.
module key_debouncer #(
  parameter int N_KEYS        = 2,
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = 20,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [N_KEYS-1:0] sync1_r;
  logic [N_KEYS-1:0] sync2_r;
  logic [N_KEYS-1:0] stable_r;
  logic [CNT_W-1:0]  cnt_r [N_KEYS];
  logic [N_KEYS-1:0] press_r;
  logic [N_KEYS-1:0] release_r;
  logic [N_KEYS-1:0] mismatch_s;
  logic [N_KEYS-1:0] accept_s;
  logic [N_KEYS-1:0] press_next_s;
  logic [N_KEYS-1:0] release_next_s;

  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("key_debouncer: STABLE_CYCLES must be at least 2");
  end
  if ((CNT_W < 1) || (CNT_W > 30) || ((STABLE_CYCLES - 1) >= (1 << CNT_W))) begin : g_bad_cnt_w
    $error("key_debouncer: CNT_W cannot hold STABLE_CYCLES-1");
  end

  // Two-flop synchroniser; idles at the released (high) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= {N_KEYS{1'b1}};
      sync2_r <= {N_KEYS{1'b1}};
    end else begin
      sync1_r <= key_n_in;
      sync2_r <= sync1_r;
    end
  end

  // Mismatch against the accepted level and acceptance on the final counted sample.
  always_comb begin
    mismatch_s = {N_KEYS{1'b0}};
    accept_s   = {N_KEYS{1'b0}};
    for (int i = 0; i < N_KEYS; i++) begin
      mismatch_s[i] = (~sync2_r[i]) != stable_r[i];
      accept_s[i]   = mismatch_s[i] && (cnt_r[i] == STABLE_MAX);
    end
  end

  // Stability counter and accepted level; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_r <= {N_KEYS{1'b0}};
      for (int i = 0; i < N_KEYS; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (!mismatch_s[i]) begin
          cnt_r[i] <= {CNT_W{1'b0}};
        end else if (accept_s[i]) begin
          cnt_r[i]    <= {CNT_W{1'b0}};
          stable_r[i] <= ~stable_r[i];
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX) + 1;
  // Counter restarts on the cycle after each press pulse, hence the two-cycle offset.
  localparam logic [RPT_W-1:0] DELAY_TGT  = RPT_W'(REPEAT_DELAY - 2);
  localparam logic [RPT_W-1:0] PERIOD_TGT = RPT_W'(REPEAT_PERIOD - 2);

  logic [RPT_W-1:0]  rpt_cnt_r [N_KEYS];
  logic [N_KEYS-1:0] rpt_phase_r;
  logic [N_KEYS-1:0] rpt_fire_s;

  if ((REPEAT_DELAY < 2) || (REPEAT_PERIOD < 2)) begin : g_bad_repeat
    $error("key_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be at least 2");
  end

  // Repeat fires only while the accepted level is held and not being released.
  always_comb begin
    rpt_fire_s = {N_KEYS{1'b0}};
    for (int i = 0; i < N_KEYS; i++) begin
      rpt_fire_s[i] = stable_r[i] && !accept_s[i] && !press_r[i] &&
                      (rpt_cnt_r[i] == (rpt_phase_r[i] ? PERIOD_TGT : DELAY_TGT));
    end
  end

  // Held-time counter; phase selects first delay versus steady repeat period.
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_phase_r <= {N_KEYS{1'b0}};
      for (int i = 0; i < N_KEYS; i++) begin
        rpt_cnt_r[i] <= {RPT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (!stable_r[i]) begin
          rpt_cnt_r[i]   <= {RPT_W{1'b0}};
          rpt_phase_r[i] <= 1'b0;
        end else if (press_r[i]) begin
          rpt_cnt_r[i] <= {RPT_W{1'b0}};
        end else begin
          rpt_cnt_r[i] <= rpt_cnt_r[i] + RPT_W'(1);
          if (rpt_fire_s[i]) begin
            rpt_phase_r[i] <= 1'b1;
          end
        end
      end
    end
  end
`else
  if ((REPEAT_DELAY < 0) || (REPEAT_PERIOD < 0)) begin : g_bad_repeat
    $error("key_debouncer: REPEAT_DELAY and REPEAT_PERIOD must not be negative");
  end
`endif

  // Edge pulses are decoded from the acceptance event, so they align with the level change.
  always_comb begin
    press_next_s   = {N_KEYS{1'b0}};
    release_next_s = {N_KEYS{1'b0}};
    for (int i = 0; i < N_KEYS; i++) begin
      press_next_s[i]   = accept_s[i] & ~stable_r[i];
      release_next_s[i] = accept_s[i] &  stable_r[i];
    end
`ifdef KEY_AUTOREPEAT_EN
    press_next_s = press_next_s | rpt_fire_s;
`endif
  end

  // Registered press/release pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_r   <= {N_KEYS{1'b0}};
      release_r <= {N_KEYS{1'b0}};
    end else begin
      press_r   <= press_next_s;
      release_r <= release_next_s;
    end
  end

  assign key_level   = stable_r;
  assign key_press   = press_r;
  assign key_release = release_r;

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Inputs change 1 ns after a rising edge; k=1 is the first edge that samples the new level.
module tb_key_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key_n_in;
  logic [1:0] key_level;
  logic [1:0] key_press;
  logic [1:0] key_release;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_debouncer #(
    .N_KEYS(2), .STABLE_CYCLES(4), .CNT_W(8), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .rst(rst), .key_n_in(key_n_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release)
  );

  task automatic test_reset();
    logic [1:0] el, ep;
    rst = 1'b1;
    key_n_in = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({key_level, key_press, key_release} !== 6'b000000) begin
        n_err++;
        $display("FAIL reset_hold k=%0d: got %b/%b/%b expected 00/00/00", k, key_level, key_press, key_release);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      el = (k >= 6) ? 2'b11 : 2'b00;
      ep = (k == 6) ? 2'b11 : 2'b00;
      n_vec++;
      if ({key_level, key_press, key_release} !== {el, ep, 2'b00}) begin
        n_err++;
        $display("FAIL reset_release k=%0d: got %b/%b/%b expected %b/%b/00", k, key_level, key_press, key_release, el, ep);
      end
    end
  endtask

  task automatic test_release_both();
    logic [1:0] el, er;
    key_n_in = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      el = (k >= 6) ? 2'b00 : 2'b11;
      er = (k == 6) ? 2'b11 : 2'b00;
      n_vec++;
      if ({key_level, key_press, key_release} !== {el, 2'b00, er}) begin
        n_err++;
        $display("FAIL release_both k=%0d: got %b/%b/%b expected %b/00/%b", k, key_level, key_press, key_release, el, er);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [1:0] el, ep;
    key_n_in = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      el = (k >= 6) ? 2'b01 : 2'b00;
      ep = (k == 6) ? 2'b01 : 2'b00;
      n_vec++;
      if ({key_level, key_press, key_release} !== {el, ep, 2'b00}) begin
        n_err++;
        $display("FAIL clean_press k=%0d: got %b/%b/%b expected %b/%b/00", k, key_level, key_press, key_release, el, ep);
      end
    end
  endtask

  task automatic test_release();
    logic [1:0] el, er;
    key_n_in = 2'b11;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      el = (k >= 6) ? 2'b00 : 2'b01;
      er = (k == 6) ? 2'b01 : 2'b00;
      n_vec++;
      if ({key_level, key_press, key_release} !== {el, 2'b00, er}) begin
        n_err++;
        $display("FAIL release k=%0d: got %b/%b/%b expected %b/00/%b", k, key_level, key_press, key_release, el, er);
      end
    end
  endtask

  task automatic test_bounce();
    logic [11:0] raw;
    // LSB first: low 3, high 1, low 2, then high.
    raw = 12'b1111_1100_1000;
    for (int k = 1; k <= 12; k++) begin
      key_n_in = {1'b1, raw[k-1]};
      @(posedge clk); #1;
      n_vec++;
      if ({key_level, key_press, key_release} !== 6'b000000) begin
        n_err++;
        $display("FAIL bounce k=%0d: got %b/%b/%b expected 00/00/00", k, key_level, key_press, key_release);
      end
    end
    key_n_in = 2'b11;
  endtask

  task automatic test_independence();
    logic [1:0] el, ep, er;
    key_n_in = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      el = (k >= 6) ? 2'b10 : 2'b00;
      ep = (k == 6) ? 2'b10 : 2'b00;
      n_vec++;
      if ({key_level, key_press, key_release} !== {el, ep, 2'b00}) begin
        n_err++;
        $display("FAIL indep_setup k=%0d: got %b/%b/%b expected %b/%b/00", k, key_level, key_press, key_release, el, ep);
      end
    end
    key_n_in = 2'b10;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      el = (k >= 6) ? 2'b01 : 2'b10;
      ep = (k == 6) ? 2'b01 : 2'b00;
      er = (k == 6) ? 2'b10 : 2'b00;
      n_vec++;
      if ({key_level, key_press, key_release} !== {el, ep, er}) begin
        n_err++;
        $display("FAIL independence k=%0d: got %b/%b/%b expected %b/%b/%b", k, key_level, key_press, key_release, el, ep, er);
      end
    end
  endtask

  task automatic test_autorepeat();
    logic [1:0] el, ep, er;
    // Key0 releases and key1 presses together; key1 is accepted at k=6 (held cycle 0).
    key_n_in = 2'b01;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      el = (k < 6) ? 2'b01 : ((k < 30) ? 2'b10 : 2'b00);
      ep = (k == 6) ? 2'b10 : 2'b00;
      er = (k == 6) ? 2'b01 : ((k == 30) ? 2'b10 : 2'b00);
`ifdef KEY_AUTOREPEAT_EN
      if ((k == 16) || (k == 19) || (k == 22) || (k == 25) || (k == 28)) ep = 2'b10;
`endif
      n_vec++;
      if ({key_level, key_press, key_release} !== {el, ep, er}) begin
        n_err++;
        $display("FAIL autorepeat k=%0d: got %b/%b/%b expected %b/%b/%b", k, key_level, key_press, key_release, el, ep, er);
      end
      if (k == 24) key_n_in = 2'b11;
    end
  endtask

  task automatic test_reset_midcount();
    logic [1:0] el, ep;
    key_n_in = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({key_level, key_press, key_release} !== 6'b000000) begin
        n_err++;
        $display("FAIL midcount_pre k=%0d: got %b/%b/%b expected 00/00/00", k, key_level, key_press, key_release);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({key_level, key_press, key_release} !== 6'b000000) begin
      n_err++;
      $display("FAIL midcount_rst: got %b/%b/%b expected 00/00/00", key_level, key_press, key_release);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      el = (k >= 6) ? 2'b11 : 2'b00;
      ep = (k == 6) ? 2'b11 : 2'b00;
      n_vec++;
      if ({key_level, key_press, key_release} !== {el, ep, 2'b00}) begin
        n_err++;
        $display("FAIL midcount_post k=%0d: got %b/%b/%b expected %b/%b/00", k, key_level, key_press, key_release, el, ep);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    key_n_in = 2'b11;
    test_reset();
    test_release_both();
    test_clean_press();
    test_release();
    test_bounce();
    test_independence();
    test_autorepeat();
    test_reset_midcount();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
